// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared constants for the multicycle MIPS control unit: instruction opcodes,
// R-type funct codes, ALUControl encodings, the ALU operation selector used
// between the FSM and the ALU decoder, and the FSM state encoding.
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALUControl encodings
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Operation class requested by the FSM from the ALU decoder
    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } aluop_t;

    // FSM states; encodings 12..15 are unused and recover to FETCH
    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTE  = 4'd6,
        S_ALUWB    = 4'd7,
        S_BRANCH   = 4'd8,
        S_ADDIEX   = 4'd9,
        S_ADDIWB   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    // True for opcodes the controller knows how to sequence
    function automatic logic is_supported_op(input logic [5:0] op);
        logic ok;
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: ok = 1'b1;
            default:                                       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// -----------------------------------------------------------------------------
// mc_alu_dec
// Purely combinational ALU decoder. Maps the FSM's operation class (add, sub,
// or "use funct") and the R-type funct field onto the 3-bit ALUControl.
// Ports:
//   aluop         in   2  operation class from the FSM
//   funct         in   6  instr[5:0]
//   alu_control   out  3  ALUControl encoding
//   funct_illegal out  1  funct not supported (only meaningful for ALUOP_FUNCT)
// -----------------------------------------------------------------------------
module mc_alu_dec
    import mips_ctrl_pkg::*;
(
    input  aluop_t     aluop,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    // Decode operation class and funct into ALUControl; unknown funct falls back to add
    always_comb begin
        alu_control   = ALU_ADD;
        funct_illegal = 1'b0;
        case (aluop)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD: alu_control = ALU_ADD;
                    FN_SUB: alu_control = ALU_SUB;
                    FN_AND: alu_control = ALU_AND;
                    FN_OR:  alu_control = ALU_OR;
                    FN_SLT: alu_control = ALU_SLT;
                    default: begin
                        alu_control   = ALU_ADD;
                        funct_illegal = 1'b1;
                    end
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// Control FSM for a multicycle MIPS datapath (lw, sw, R-type, beq, addi, j).
// Datapath selects are decoded from the current state; memory-qualified
// strobes (IRWrite/PCEn in FETCH, PCEn in BRANCH) follow mem_ready / zero in
// the same cycle so a stalled access never commits. Also counts retired
// instructions.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   opcode, funct       instruction fields from the instruction register
//   zero                ALU zero flag (beq decision)
//   mem_ready           completion of the current memory request
//   mem_req, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA,
//   ALUSrcB[1:0], PCSrc[1:0], PCEn, ALUControl[2:0]   datapath control
//   state_o[3:0]        current state (debug)
//   illegal_op          one-cycle pulse on unsupported opcode/funct
//   instr_count[31:0]   retired-instruction counter (wraps)
// -----------------------------------------------------------------------------
module multicycle_controller
    import mips_ctrl_pkg::*;
#(
    parameter int IMEM_WAIT_OK = 1
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        IorD,
    output logic        MemWrite,
    output logic        IRWrite,
    output logic        RegDst,
    output logic        MemToReg,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  PCSrc,
    output logic        PCEn,
    output logic [2:0]  ALUControl,
    output logic [3:0]  state_o,
    output logic        illegal_op,
    output logic [31:0] instr_count
);

    state_t      state_q, state_d;
    logic [31:0] instr_count_q, instr_count_d;

    logic        ready_s;
    logic        retire_s;
    logic        mem_req_s, iord_s, memwrite_s, irwrite_s;
    logic        regdst_s, memtoreg_s, regwrite_s, alusrca_s, pcen_s;
    logic [1:0]  alusrcb_s, pcsrc_s;
    logic        illegal_s;
    aluop_t      aluop_s;
    logic [2:0]  alu_control_s;
    logic        funct_illegal_s;

    // With stalls disabled every memory access is treated as completing at once
    assign ready_s = (IMEM_WAIT_OK != 0) ? mem_ready : 1'b1;

    mc_alu_dec u_alu_dec (
        .aluop         (aluop_s),
        .funct         (funct),
        .alu_control   (alu_control_s),
        .funct_illegal (funct_illegal_s)
    );

    // Next-state, retirement and per-state datapath control decode
    always_comb begin
        state_d    = S_FETCH;
        retire_s   = 1'b0;
        mem_req_s  = 1'b0;
        iord_s     = 1'b0;
        memwrite_s = 1'b0;
        irwrite_s  = 1'b0;
        regdst_s   = 1'b0;
        memtoreg_s = 1'b0;
        regwrite_s = 1'b0;
        alusrca_s  = 1'b0;
        alusrcb_s  = 2'b00;
        pcsrc_s    = 2'b00;
        pcen_s     = 1'b0;
        illegal_s  = 1'b0;
        aluop_s    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                // PC+4 computed every cycle; IR and PC only load on completion
                mem_req_s = 1'b1;
                alusrcb_s = 2'b01;
                if (ready_s) begin
                    irwrite_s = 1'b1;
                    pcen_s    = 1'b1;
                    state_d   = S_DECODE;
                end else begin
                    state_d   = S_FETCH;
                end
            end
            S_DECODE: begin
                // Branch target precomputed into ALUOut while decoding
                alusrcb_s = 2'b11;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTE;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_s = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                if (opcode == OP_SW) begin
                    state_d = S_MEMWRITE;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMREAD: begin
                mem_req_s = 1'b1;
                iord_s    = 1'b1;
                if (ready_s) begin
                    state_d = S_MEMWB;
                end else begin
                    state_d = S_MEMREAD;
                end
            end
            S_MEMWB: begin
                memtoreg_s = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                // MemWrite held through every stall cycle of the store
                mem_req_s  = 1'b1;
                iord_s     = 1'b1;
                memwrite_s = 1'b1;
                if (ready_s) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEMWRITE;
                end
            end
            S_EXECUTE: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_FUNCT;
                illegal_s = funct_illegal_s;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                regdst_s   = 1'b1;
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alusrca_s = 1'b1;
                aluop_s   = ALUOP_SUB;
                pcsrc_s   = 2'b01;
                pcen_s    = zero;
                retire_s  = 1'b1;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_s = 1'b1;
                alusrcb_s = 2'b10;
                state_d   = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_s = 1'b1;
                retire_s   = 1'b1;
                state_d    = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_s  = 2'b10;
                pcen_s   = 1'b1;
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Retire counter next value; wraps naturally at 32 bits
    always_comb begin
        if (retire_s) begin
            instr_count_d = instr_count_q + 32'd1;
        end else begin
            instr_count_d = instr_count_q;
        end
    end

    // FSM state and retire counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FETCH;
            instr_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            instr_count_q <= instr_count_d;
        end
    end

    // Side-effecting strobes are gated by rst_n so they drop the instant reset asserts
    assign mem_req    = mem_req_s  & rst_n;
    assign MemWrite   = memwrite_s & rst_n;
    assign IRWrite    = irwrite_s  & rst_n;
    assign RegWrite   = regwrite_s & rst_n;
    assign PCEn       = pcen_s     & rst_n;
    assign illegal_op = illegal_s  & rst_n;

    assign IorD        = iord_s;
    assign RegDst      = regdst_s;
    assign MemToReg    = memtoreg_s;
    assign ALUSrcA     = alusrca_s;
    assign ALUSrcB     = alusrcb_s;
    assign PCSrc       = pcsrc_s;
    assign ALUControl  = alu_control_s;
    assign state_o     = state_q;
    assign instr_count = instr_count_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Each instruction is expanded into a per-cycle list of expected outputs
// (driven mem_ready included) built from the instruction's documented cycle
// sequence; one loop drives inputs and compares every output each cycle.
// A second instance with IMEM_WAIT_OK = 0 and mem_ready tied low runs lw
// back-to-back and is checked against a 5-cycle period.
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  opcode = 6'd0;
    logic [5:0]  funct = 6'd0;
    logic        zero = 1'b0;
    logic        mem_ready = 1'b0;

    logic        mem_req, IorD, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, PCSrc;
    logic        PCEn, illegal_op;
    logic [2:0]  ALUControl;
    logic [3:0]  state_o;
    logic [31:0] instr_count;

    logic        nw_mem_req, nw_iord, nw_memwrite, nw_irwrite, nw_regdst, nw_memtoreg;
    logic        nw_regwrite, nw_alusrca, nw_pcen, nw_illegal;
    logic [1:0]  nw_alusrcb, nw_pcsrc;
    logic [2:0]  nw_aluctl;
    logic [3:0]  nw_state;
    logic [31:0] nw_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemToReg(MemToReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .PCEn(PCEn),
        .ALUControl(ALUControl), .state_o(state_o), .illegal_op(illegal_op),
        .instr_count(instr_count)
    );

    multicycle_controller #(.IMEM_WAIT_OK(0)) u_nw (
        .clk(clk), .rst_n(rst_n), .opcode(6'b100011), .funct(6'b000000), .zero(1'b0),
        .mem_ready(1'b0), .mem_req(nw_mem_req), .IorD(nw_iord), .MemWrite(nw_memwrite),
        .IRWrite(nw_irwrite), .RegDst(nw_regdst), .MemToReg(nw_memtoreg),
        .RegWrite(nw_regwrite), .ALUSrcA(nw_alusrca), .ALUSrcB(nw_alusrcb),
        .PCSrc(nw_pcsrc), .PCEn(nw_pcen), .ALUControl(nw_aluctl), .state_o(nw_state),
        .illegal_op(nw_illegal), .instr_count(nw_count)
    );

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] fn;
        logic       zr;
        logic       mr;
        logic [3:0] st;
        logic       mem_req, iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
        logic [1:0] alusrcb, pcsrc;
        logic       pcen;
        logic [2:0] aluctl;
        logic       illegal;
        logic       retire;
    } exp_t;

    exp_t        tq[$];
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at t=%0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    function automatic logic legal_op(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    function automatic logic legal_fn(input logic [5:0] fn);
        return (fn == 6'b100000) || (fn == 6'b100010) || (fn == 6'b100100) ||
               (fn == 6'b100101) || (fn == 6'b101010);
    endfunction

    function automatic exp_t base(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                                  input logic [3:0] st, input logic mr);
        exp_t e;
        e = '0;
        e.op = op; e.fn = fn; e.zr = zr; e.st = st; e.mr = mr;
        e.aluctl = 3'b010;
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected cycles
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic zr,
                         input int fst, input int mst);
        exp_t e;
        for (int i = 0; i < fst; i++) begin
            e = base(op, fn, zr, 4'd0, 1'b0); e.mem_req = 1'b1; e.alusrcb = 2'b01; tq.push_back(e);
        end
        e = base(op, fn, zr, 4'd0, 1'b1); e.mem_req = 1'b1; e.alusrcb = 2'b01;
        e.irwrite = 1'b1; e.pcen = 1'b1; tq.push_back(e);
        e = base(op, fn, zr, 4'd1, rb()); e.alusrcb = 2'b11; e.illegal = !legal_op(op);
        tq.push_back(e);
        if (op == 6'b100011 || op == 6'b101011) begin
            e = base(op, fn, zr, 4'd2, rb()); e.alusrca = 1'b1; e.alusrcb = 2'b10; tq.push_back(e);
            for (int i = 0; i <= mst; i++) begin
                e = base(op, fn, zr, (op == 6'b100011) ? 4'd3 : 4'd5, (i == mst));
                e.mem_req = 1'b1; e.iord = 1'b1;
                e.memwrite = (op == 6'b101011);
                e.retire = (op == 6'b101011) && (i == mst);
                tq.push_back(e);
            end
            if (op == 6'b100011) begin
                e = base(op, fn, zr, 4'd4, rb()); e.memtoreg = 1'b1; e.regwrite = 1'b1;
                e.retire = 1'b1; tq.push_back(e);
            end
        end else if (op == 6'b000000) begin
            e = base(op, fn, zr, 4'd6, rb()); e.alusrca = 1'b1; e.aluctl = alu_of(fn);
            e.illegal = !legal_fn(fn); tq.push_back(e);
            e = base(op, fn, zr, 4'd7, rb()); e.regdst = 1'b1; e.regwrite = 1'b1;
            e.retire = 1'b1; tq.push_back(e);
        end else if (op == 6'b000100) begin
            e = base(op, fn, zr, 4'd8, rb()); e.alusrca = 1'b1; e.aluctl = 3'b110;
            e.pcsrc = 2'b01; e.pcen = zr; e.retire = 1'b1; tq.push_back(e);
        end else if (op == 6'b001000) begin
            e = base(op, fn, zr, 4'd9, rb()); e.alusrca = 1'b1; e.alusrcb = 2'b10; tq.push_back(e);
            e = base(op, fn, zr, 4'd10, rb()); e.regwrite = 1'b1; e.retire = 1'b1; tq.push_back(e);
        end else if (op == 6'b000010) begin
            e = base(op, fn, zr, 4'd11, rb()); e.pcsrc = 2'b10; e.pcen = 1'b1;
            e.retire = 1'b1; tq.push_back(e);
        end
    endtask

    // Drive and check up to n queued cycles (n < 0: all); entered at posedge+1
    task automatic run(input int n);
        exp_t e;
        int   k = 0;
        while (tq.size() > 0 && (n < 0 || k < n)) begin
            e = tq.pop_front();
            k++;
            opcode = e.op; funct = e.fn; zero = e.zr; mem_ready = e.mr;
            @(negedge clk);
            chk("state",      {28'd0, state_o},    {28'd0, e.st});
            chk("mem_req",    {31'd0, mem_req},    {31'd0, e.mem_req});
            chk("IorD",       {31'd0, IorD},       {31'd0, e.iord});
            chk("MemWrite",   {31'd0, MemWrite},   {31'd0, e.memwrite});
            chk("IRWrite",    {31'd0, IRWrite},    {31'd0, e.irwrite});
            chk("RegDst",     {31'd0, RegDst},     {31'd0, e.regdst});
            chk("MemToReg",   {31'd0, MemToReg},   {31'd0, e.memtoreg});
            chk("RegWrite",   {31'd0, RegWrite},   {31'd0, e.regwrite});
            chk("ALUSrcA",    {31'd0, ALUSrcA},    {31'd0, e.alusrca});
            chk("ALUSrcB",    {30'd0, ALUSrcB},    {30'd0, e.alusrcb});
            chk("PCSrc",      {30'd0, PCSrc},      {30'd0, e.pcsrc});
            chk("PCEn",       {31'd0, PCEn},       {31'd0, e.pcen});
            chk("ALUControl", {29'd0, ALUControl}, {29'd0, e.aluctl});
            chk("illegal_op", {31'd0, illegal_op}, {31'd0, e.illegal});
            chk("instr_count", instr_count, exp_cnt);
            if (e.retire) exp_cnt = exp_cnt + 32'd1;
            @(posedge clk);
            #1;
        end
    endtask

    // Assert reset asynchronously mid-cycle, check immediate effect, release at posedge+1
    task automatic reset_now(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        chk({tag, "_state"},    {28'd0, state_o}, 32'd0);
        chk({tag, "_strobes"},  {26'd0, mem_req, MemWrite, IRWrite, RegWrite, PCEn, illegal_op}, 32'd0);
        chk({tag, "_count"},    instr_count, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tq.delete();
        exp_cnt = 32'd0;
    endtask

    // No-wait instance: lw repeats every 5 cycles regardless of mem_ready
    int          nw_ph  = 0;
    logic [31:0] nw_exp = 32'd0;
    always @(negedge clk) begin
        if (!rst_n) begin
            nw_ph  = 0;
            nw_exp = 32'd0;
        end else begin
            chk("nowait_state", {28'd0, nw_state}, nw_ph);
            chk("nowait_count", nw_count, nw_exp);
            if (nw_ph == 4) nw_exp = nw_exp + 32'd1;
            nw_ph = (nw_ph + 1) % 5;
        end
    end

    logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
    logic [5:0] fns [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    initial begin
        logic [5:0] op, fn;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state",   {28'd0, state_o}, 32'd0);
        chk("reset_strobes", {26'd0, mem_req, MemWrite, IRWrite, RegWrite, PCEn, illegal_op}, 32'd0);
        chk("reset_count",   instr_count, 32'd0);
        rst_n = 1'b1;

        // lw, zero wait: 5 cycles, count 0 -> 1
        build(6'b100011, 6'd0, 1'b0, 0, 0);
        chk("lw_len", tq.size(), 32'd5);
        run(-1);
        chk("lw_count", instr_count, 32'd1);

        // sw with 3 stall cycles in MEMWRITE: 7 cycles
        build(6'b101011, 6'd0, 1'b0, 0, 3);
        chk("sw_len", tq.size(), 32'd7);
        run(-1);
        chk("sw_count", instr_count, 32'd2);

        // beq taken / not taken
        build(6'b000100, 6'd0, 1'b1, 0, 0);
        chk("beq_len", tq.size(), 32'd3);
        run(-1);
        build(6'b000100, 6'd0, 1'b0, 1, 0);
        run(-1);

        // R-type slt then unsupported funct
        build(6'b000000, 6'b101010, 1'b0, 0, 0);
        chk("rtype_len", tq.size(), 32'd4);
        run(-1);
        build(6'b000000, 6'b111111, 1'b0, 0, 0);
        run(-1);
        chk("rtype_count", instr_count, 32'd6);

        // unsupported opcode: 2 cycles, no retire
        build(6'b111111, 6'd0, 1'b0, 0, 0);
        chk("illop_len", tq.size(), 32'd2);
        run(-1);
        chk("illop_count", instr_count, 32'd6);

        // addi and j, with fetch stalls
        build(6'b001000, 6'd0, 1'b0, 2, 0);
        chk("addi_len", tq.size(), 32'd6);
        run(-1);
        build(6'b000010, 6'd0, 1'b0, 1, 0);
        chk("j_len", tq.size(), 32'd4);
        run(-1);
        chk("j_count", instr_count, 32'd8);

        // randomized instruction stream
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 6) == 6) begin
                op = 6'($urandom_range(0, 63));
                while (legal_op(op)) op = 6'($urandom_range(0, 63));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            if ($urandom_range(0, 4) == 0) fn = 6'($urandom_range(0, 63));
            else fn = fns[$urandom_range(0, 4)];
            build(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
            run(-1);
        end

        // reset during a FETCH stall
        build(6'b100011, 6'd0, 1'b0, 3, 0);
        run(2);
        mem_ready = 1'b0;
        reset_now("rst_fetch");

        // preload counter to all-ones and retire a jump: wraps to 0
        mem_ready = 1'b0;
        force dut.instr_count_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.instr_count_q;
        chk("preload", instr_count, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        exp_cnt = 32'hFFFF_FFFF;
        build(6'b000010, 6'd0, 1'b0, 0, 0);
        run(-1);
        chk("wrap_count", instr_count, 32'd0);

        // reset during a MEMREAD stall
        build(6'b100011, 6'd0, 1'b0, 0, 4);
        run(5);
        mem_ready = 1'b0;
        reset_now("rst_memread");
        build(6'b000000, 6'b100000, 1'b0, 0, 0);
        run(-1);
        chk("post_reset_count", instr_count, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
